// File: rtl/ram_stream_reader_if.sv
// Read-port and output-stream bundle for ram_stream_reader: the RAM read port
// (address, enable, returned word) and the valid/ready word stream with last marking.
interface ram_stream_reader_if #(
    parameter int BDADDR = 12,
    parameter int BDWORD = 32*64
) ();
    logic              ram_rd_en;
    logic [BDADDR-1:0] ram_rd_addr;
    logic [BDWORD-1:0] ram_rd_word;
    logic              out_valid;
    logic              out_ready;
    logic [BDWORD-1:0] out_word;
    logic              out_last;

    modport master (
        output ram_rd_en, ram_rd_addr, out_valid, out_word, out_last,
        input  ram_rd_word, out_ready
    );

    modport slave (
        input  ram_rd_en, ram_rd_addr, out_valid, out_word, out_last,
        output ram_rd_word, out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Read sequencer: walks base/stride/length over a 1-cycle-latency RAM and streams the words.
// Optional feature macro: RAM_STREAM_READER_STRIDE_EN (stride port; otherwise increment is 1).

module ram_stream_reader_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic head_free,
    input logic skid_valid
);
    // A returning word must always find a free FIFO slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !head_free && skid_valid));
endmodule

module ram_stream_reader #(
    parameter int BDADDR = 12,
    parameter int BDWORD = 32*64,
    parameter int BDLEN  = BDADDR + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BDADDR-1:0] base_addr,
    input  logic [BDLEN-1:0]  length,
`ifdef RAM_STREAM_READER_STRIDE_EN
    input  logic [BDADDR-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic [BDLEN-1:0]  len_r;
    logic [BDLEN-1:0]  issued_r;
    logic [BDADDR-1:0] stride_r;
    logic [BDADDR-1:0] addr_r;
    logic              busy_r;
    logic              done_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [BDWORD-1:0] out_word_r;
    logic              skid_valid_r;
    logic              skid_last_r;
    logic [BDWORD-1:0] skid_word_r;

    logic              pop_s;
    logic              push_s;
    logic              head_free_s;
    logic              rd_en_s;
    logic              issue_last_s;
    logic [1:0]        occ_s;
    logic [BDADDR-1:0] stride_in_s;

`ifdef RAM_STREAM_READER_STRIDE_EN
    assign stride_in_s = stride;
`else
    assign stride_in_s = {{(BDADDR-1){1'b0}}, 1'b1};
`endif

    // Handshake decode and read-issue decision.
    always_comb begin
        pop_s        = out_valid_r && bus.out_ready;
        push_s       = inflight_r;
        head_free_s  = !out_valid_r || pop_s;
        // Occupancy net of the word leaving this cycle keeps the stream at full rate.
        occ_s        = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, inflight_r}
                       - {1'b0, pop_s};
        issue_last_s = (issued_r == (len_r - {{(BDLEN-1){1'b0}}, 1'b1}));
        if ((state_r == ST_RUN) && (issued_r < len_r) && (occ_s < 2'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Command sequencing, address walk and completion signalling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            len_r           <= {BDLEN{1'b0}};
            issued_r        <= {BDLEN{1'b0}};
            stride_r        <= {BDADDR{1'b0}};
            addr_r          <= {BDADDR{1'b0}};
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            done_r          <= 1'b0;
            inflight_r      <= rd_en_s;
            inflight_last_r <= rd_en_s && issue_last_s;
            if (rd_en_s) begin
                addr_r   <= addr_r + stride_r;
                issued_r <= issued_r + {{(BDLEN-1){1'b0}}, 1'b1};
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (length != {BDLEN{1'b0}}) begin
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                            len_r    <= length;
                            stride_r <= stride_in_s;
                            addr_r   <= base_addr;
                            issued_r <= {BDLEN{1'b0}};
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_en_s && issue_last_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && out_last_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry FIFO: the head register is the stream output, the skid entry holds the next word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_word_r   <= {BDWORD{1'b0}};
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_word_r  <= {BDWORD{1'b0}};
        end else if (head_free_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_word_r   <= skid_word_r;
                out_last_r   <= skid_last_r;
                skid_valid_r <= push_s;
                if (push_s) begin
                    skid_word_r <= bus.ram_rd_word;
                    skid_last_r <= inflight_last_r;
                end
            end else if (push_s) begin
                out_valid_r <= 1'b1;
                out_word_r  <= bus.ram_rd_word;
                out_last_r  <= inflight_last_r;
            end else begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end else if (push_s) begin
            skid_valid_r <= 1'b1;
            skid_word_r  <= bus.ram_rd_word;
            skid_last_r  <= inflight_last_r;
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign bus.ram_rd_en   = rd_en_s;
    assign bus.ram_rd_addr = addr_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_word    = out_word_r;
    assign bus.out_last    = out_last_r;

    ram_stream_reader_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .head_free  (head_free_s),
        .skid_valid (skid_valid_r)
    );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: directed commands push expected addresses and
// words into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_ram_stream_reader;
    localparam int BDADDR = 12;
    localparam int BDWORD = 2048;
    localparam int BDLEN  = 13;

    typedef struct {
        logic [BDWORD-1:0] word;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [BDADDR-1:0] base_addr = 12'h000;
    logic [BDLEN-1:0]  length = 13'h0000;
`ifdef RAM_STREAM_READER_STRIDE_EN
    logic [BDADDR-1:0] stride = 12'h001;
`endif
    logic              busy;
    logic              done;
    bit                ready_toggle = 1'b0;

    int                n_checks = 0;
    int                n_fail = 0;
    exp_t              exp_q[$];
    logic [BDADDR-1:0] addr_q[$];

    ram_stream_reader_if #(.BDADDR(BDADDR), .BDWORD(BDWORD)) bus ();

    ram_stream_reader #(.BDADDR(BDADDR), .BDWORD(BDWORD), .BDLEN(BDLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef RAM_STREAM_READER_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [BDWORD-1:0] word_of(input logic [BDADDR-1:0] a);
        logic [31:0] chunk;
        chunk = {8'hC3, a, ~a};
        return {64{chunk}};
    endfunction

    // RAM model: registered read, zeros when not enabled
    always @(posedge clk) bus.ram_rd_word <= bus.ram_rd_en ? word_of(bus.ram_rd_addr) : {BDWORD{1'b0}};

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = ready_toggle ? ~bus.out_ready : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [BDWORD-1:0] act, input logic [BDWORD-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low32 %08h, expected low32 %08h (t=%0t)", name, act[31:0], exp[31:0], $time);
        end
    endtask

    task automatic fail_unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got DUT activity, expected none (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard
    initial begin
        logic              exp_done;
        int                outstanding;
        logic              stall_prev;
        logic [BDWORD-1:0] word_prev;
        logic              last_prev;
        exp_t              e;
        exp_done    = 1'b0;
        outstanding = 0;
        stall_prev  = 1'b0;
        word_prev   = {BDWORD{1'b0}};
        last_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done    = 1'b0;
                outstanding = 0;
                stall_prev  = 1'b0;
            end else begin
                chk("done", done, exp_done);
                if (exp_done) chk("busy_at_done", busy, 1'b0);
                exp_done = 1'b0;
                if (stall_prev) begin
                    chk("stall_valid", bus.out_valid, 1'b1);
                    chk_word("stall_word", bus.out_word, word_prev);
                    chk("stall_last", bus.out_last, last_prev);
                end
                if (bus.ram_rd_en) begin
                    outstanding++;
                    if (addr_q.size() == 0) fail_unexpected("rd_en");
                    else chk("rd_addr", bus.ram_rd_addr, addr_q.pop_front());
                end
                if (bus.out_valid && bus.out_ready) begin
                    outstanding--;
                    if (exp_q.size() == 0) fail_unexpected("out_word");
                    else begin
                        e = exp_q.pop_front();
                        chk_word("out_word", bus.out_word, e.word);
                        chk("out_last", bus.out_last, e.last);
                        if (e.last) exp_done = 1'b1;
                    end
                end
                if (bus.ram_rd_en) chk("outstanding_le2", (outstanding <= 2), 1'b1);
                if (start && !busy && (length == 13'h0000)) exp_done = 1'b1;
                stall_prev = bus.out_valid && !bus.out_ready;
                word_prev  = bus.out_word;
                last_prev  = bus.out_last;
            end
        end
    end

    task automatic run_cmd(input logic [BDADDR-1:0] base, input logic [BDLEN-1:0] len,
                           input logic [BDADDR-1:0] strd, input int exp_first, input int exp_done_k);
        logic [BDADDR-1:0] a;
        int first;
        int dk;
        a = base;
        for (int i = 0; i < int'(len); i++) begin
            addr_q.push_back(a);
            exp_q.push_back('{word_of(a), (i == int'(len) - 1)});
            a = a + strd;
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        length    = len;
`ifdef RAM_STREAM_READER_STRIDE_EN
        stride    = strd;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        first = -1;
        dk    = -1;
        for (int k = 0; k < 300 && dk < 0; k++) begin
            @(negedge clk);
            if (len == 13'h0000) chk("len0_busy", busy, 1'b0);
            if (first < 0 && bus.out_valid) first = k;
            if (done) dk = k;
        end
        if (dk < 0) fail_unexpected("done_timeout");
        if (exp_first >= 0) chk("first_valid_edge", first, exp_first);
        if (exp_done_k >= 0) chk("done_edge", dk, exp_done_k);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BDADDR-1:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", bus.ram_rd_en, 1'b0);
        chk("rst_rd_addr", bus.ram_rd_addr, 12'h000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk_word("rst_out_word", bus.out_word, {BDWORD{1'b0}});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_cmd(12'h010, 13'd4, 12'h001, 2, 6);
        run_cmd(12'hFFE, 13'd4, 12'h001, 2, 6);
        ready_toggle = 1'b1;
        run_cmd(12'h200, 13'd8, 12'h001, -1, -1);
        ready_toggle = 1'b0;
        run_cmd(12'h055, 13'd0, 12'h001, -1, 0);
`ifdef RAM_STREAM_READER_STRIDE_EN
        run_cmd(12'h100, 13'd3, 12'h040, 2, 5);
`else
        run_cmd(12'h100, 13'd3, 12'h001, 2, 5);
`endif

        // abort a 16-word command two cycles in
        a = 12'h040;
        for (int i = 0; i < 16; i++) begin
            addr_q.push_back(a);
            exp_q.push_back('{word_of(a), (i == 15)});
            a = a + 12'h001;
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 12'h040;
        length    = 13'd16;
`ifdef RAM_STREAM_READER_STRIDE_EN
        stride    = 12'h001;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_rd_en", bus.ram_rd_en, 1'b0);
        chk("abort_rd_addr", bus.ram_rd_addr, 12'h000);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_out_last", bus.out_last, 1'b0);
        chk_word("abort_out_word", bus.out_word, {BDWORD{1'b0}});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_cmd(12'h300, 13'd3, 12'h001, 2, 5);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
